mpc_mac_pipe: RTL and testbench
===============================

Name: mpc_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit for the MPC datapath. It generalises the fixed single-product multiplier to arbitrary operand and output widths and a configurable pipeline depth. It adds valid tracking, optional multi-beat accumulation for dot products, round-half-up scaling and output saturation. Instantiated in the MPC matrix-vector kernels wherever a product or sum of products feeds the solver loop.

Parameters:
DIN0_WIDTH, 21, signed width of din0
DIN1_WIDTH, 7, signed width of din1
DOUT_WIDTH, 28, signed width of dout
ACC_WIDTH, 40, signed accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
NUM_STAGE, 4, total latency in cycles; must be >= 3
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ce  in  1  clock enable; 0 freezes every register in the block
in_valid  in  1  input beat valid
din0  in  DIN0_WIDTH  signed operand A
din1  in  DIN1_WIDTH  signed operand B
acc_first  in  1  beat starts a new sum
acc_last  in  1  beat ends a sum and emits a result
out_valid  out  1  one-cycle pulse: dout/sat_flag valid
dout  out  DOUT_WIDTH  rounded, saturated result
sat_flag  out  1  result saturated (accumulator or output), valid with out_valid

Behaviour:
- One clock, clk. reset is synchronous and active-high. Reset overrides ce.
- Reset clears all valid bits, accumulator, sticky overflow, dout, out_valid and sat_flag to 0. In-flight beats and any open partial sum are discarded.
- ce=0: no register updates. Outputs hold their values, including out_valid. Latency is counted in ce=1 cycles.
- Pipeline:
  - Product pipeline: NUM_STAGE-2 registers. The first register samples din0, din1, in_valid, acc_first and acc_last.
  - Product width is DIN0_WIDTH+DIN1_WIDTH, full precision, sign-extended to ACC_WIDTH.
  - Accumulator register: 1 stage.
  - Output register: 1 stage.
- Latency: a beat with acc_last, presented with in_valid=1 in ce cycle t, produces out_valid=1 in cycle t+NUM_STAGE.
- Throughput: one beat per cycle, no backpressure.
- Accumulate stage, for valid beats only:
  - acc_next = p if acc_first, otherwise acc + p.
  - The sum saturates at the ACC_WIDTH signed min/max and sets sticky ovf.
  - acc_first clears ovf before the add.
  - Invalid beats leave acc and ovf unchanged, so gaps inside a sum are allowed.
- Output stage: on a valid beat with acc_last, it takes the combinational acc_next and ovf_next.
  - If SHIFT>0: v = (acc_next + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up (toward +inf). If SHIFT=0: v = acc_next.
  - dout = v clamped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - sat_flag = ovf_next OR clamped.
  - out_valid=1. In all other ce cycles out_valid=0; dout and sat_flag hold.
- acc_first=acc_last=1 on every beat gives a plain pipelined multiplier.
- acc_first on a beat while a sum is open silently drops the partial sum.
- acc_last without a preceding acc_first continues from the current acc, which is 0 after reset.
- A new sum may start on the cycle after acc_last; there are no bubbles.

Decomposition:
- Package mpc_mac_pkg holds:
  - width-check constants;
  - function sat_signed(value, width) returning the clamped value and a flag;
  - function round_shift(value, shift).
- Sub-module mpc_mac_sat: combinational round, shift and clamp from ACC_WIDTH to DOUT_WIDTH. It is used by the output stage and is reusable elsewhere in the MPC datapath.
- The accumulator and pipeline stay in the top module.

Test Plan:
- Defaults, single beat, din0=-1048576, din1=-64, first=last=1 -> out_valid at t+4, dout=67108864, sat_flag=0.
- Four-beat sum, din0=1048575, din1=63, first on beat 0, last on beat 3 -> single out_valid 4 cycles after beat 3, dout=134217727, sat_flag=1.
- Back-to-back single beats, din0=1..8, din1=3 -> out_valid high 8 consecutive cycles starting t+4, dout=3,6,...,24.
- ce=0 for 3 cycles while 2 beats are in flight -> out_valid delayed by exactly 3 cycles, values unchanged, outputs held during the stall.
- Reset mid-sum: first beat (100*7), reset pulse, then last-only beat (5*3) -> dout=15, no output for the first beat.
- SHIFT=4 instance: 24*1 -> dout=2; -24*1 -> dout=-1; 8*1 -> dout=1; 7*1 -> dout=0.

Source files
------------

// File: rtl/mpc_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpc_mac_pkg
// Description : Shared types, width limits and arithmetic helpers for the
//               MPC multiply-accumulate datapath. Helpers work on one wide
//               signed type, so callers sign-extend into it and slice the
//               result back to their own width.
// Revision    : 1.0 - initial release
// ============================================================================
package mpc_mac_pkg;

    // Widest intermediate value the helpers operate on.
    localparam int unsigned c_MAX_WIDTH = 128;
    // Smallest legal pipeline depth: input register, accumulator, output.
    localparam int unsigned c_MIN_STAGE = 3;

    typedef logic signed [c_MAX_WIDTH-1:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  clamped;
    } sat_t;

    // Clamp a signed value to the range of a 'width'-bit signed number.
    function automatic sat_t sat_signed(input wide_t value, input int unsigned width);
        sat_t  res;
        wide_t lim;
        lim         = wide_t'(1) <<< (width - 1);
        res.value   = value;
        res.clamped = 1'b0;
        if (value > (lim - wide_t'(1))) begin
            res.value   = lim - wide_t'(1);
            res.clamped = 1'b1;
        end else if (value < -lim) begin
            res.value   = -lim;
            res.clamped = 1'b1;
        end
        return res;
    endfunction

    // Arithmetic right shift with round half up (toward +inf).
    function automatic wide_t round_shift(input wide_t value, input int unsigned shift);
        if (shift == 0) begin
            return value;
        end
        return (value + (wide_t'(1) <<< (shift - 1))) >>> shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpc_mac_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mpc_mac_pipe_if
// Description : Beat / result bundle of the MPC MAC pipe.
//               master : drives in_valid, din0, din1, acc_first, acc_last;
//                        receives out_valid, dout, sat_flag.
//               slave  : the MAC itself (opposite directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface mpc_mac_pipe_if #(
    parameter int unsigned DIN0_WIDTH = 21,
    parameter int unsigned DIN1_WIDTH = 7,
    parameter int unsigned DOUT_WIDTH = 28
);
    logic                         in_valid;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         acc_first;
    logic                         acc_last;
    logic                         out_valid;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         sat_flag;

    modport master (
        output in_valid, din0, din1, acc_first, acc_last,
        input  out_valid, dout, sat_flag
    );

    modport slave (
        input  in_valid, din0, din1, acc_first, acc_last,
        output out_valid, dout, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/mpc_mac_sat.sv
`default_nettype none
// ============================================================================
// Module      : mpc_mac_sat
// Description : Combinational round-half-up shift and signed clamp from an
//               ACC_WIDTH accumulator to a DOUT_WIDTH result.
//               i_acc     : signed accumulator value
//               o_dout    : rounded, clamped result
//               o_clamped : result was clamped to the output range
// Revision    : 1.0 - initial release
// ============================================================================
module mpc_mac_sat
    import mpc_mac_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned DOUT_WIDTH = 28,
    parameter int unsigned SHIFT      = 0
) (
    input  logic signed [ACC_WIDTH-1:0]  i_acc,
    output logic signed [DOUT_WIDTH-1:0] o_dout,
    output logic                         o_clamped
);
    wide_t w_rounded;
    sat_t  w_sat;
    logic  w_unused_hi;

    always_comb begin
        w_rounded = round_shift(wide_t'(i_acc), SHIFT);
        w_sat     = sat_signed(w_rounded, DOUT_WIDTH);
    end

    assign o_dout      = w_sat.value[DOUT_WIDTH-1:0];
    assign o_clamped   = w_sat.clamped;
    // Bits above DOUT_WIDTH are pure sign extension after the clamp.
    assign w_unused_hi = ^w_sat.value[c_MAX_WIDTH-1:DOUT_WIDTH];

endmodule
`default_nettype wire

// File: rtl/mpc_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mpc_mac_pipe
// Description : Pipelined signed multiply-accumulate with valid tracking,
//               multi-beat accumulation, round-half-up scaling and output
//               saturation. Latency NUM_STAGE ce-cycles, one beat per cycle.
//               clk, reset : clock, synchronous active-high reset
//               ce         : clock enable, 0 freezes every register
//               bus        : beat inputs / result outputs (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module mpc_mac_pipe
    import mpc_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 21,
    parameter int unsigned DIN1_WIDTH = 7,
    parameter int unsigned DOUT_WIDTH = 28,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned NUM_STAGE  = 4,
    parameter int unsigned SHIFT      = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    mpc_mac_pipe_if.slave bus
);
    localparam int unsigned c_PROD_W = DIN0_WIDTH + DIN1_WIDTH;
    localparam int unsigned c_NPIPE  = NUM_STAGE - 2;

    if ((ACC_WIDTH < c_PROD_W) || (NUM_STAGE < c_MIN_STAGE) ||
        (ACC_WIDTH + 2 > c_MAX_WIDTH) || (SHIFT + 2 > c_MAX_WIDTH)) begin : g_param_check
        $error("mpc_mac_pipe: illegal parameter combination");
    end

    // ---------------- product pipeline (c_NPIPE registers) ----------------
    logic signed [DIN0_WIDTH-1:0] r_a;
    logic signed [DIN1_WIDTH-1:0] r_b;
    logic [c_NPIPE-1:0]           r_vld;
    logic [c_NPIPE-1:0]           r_first;
    logic [c_NPIPE-1:0]           r_last;
    logic signed [c_PROD_W-1:0]   w_prod_s1;
    logic signed [c_PROD_W-1:0]   w_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
        end else if (ce) begin
            r_a        <= bus.din0;
            r_b        <= bus.din1;
            r_vld[0]   <= bus.in_valid;
            r_first[0] <= bus.acc_first;
            r_last[0]  <= bus.acc_last;
            for (int k = 1; k < c_NPIPE; k++) begin
                r_vld[k]   <= r_vld[k-1];
                r_first[k] <= r_first[k-1];
                r_last[k]  <= r_last[k-1];
            end
        end
    end

    // Full-precision product of the registered operands.
    assign w_prod_s1 = c_PROD_W'(r_a) * c_PROD_W'(r_b);

    if (c_NPIPE > 1) begin : g_prod_pipe
        logic signed [c_PROD_W-1:0] r_prod [1:c_NPIPE-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 1; k < c_NPIPE; k++) begin
                    r_prod[k] <= '0;
                end
            end else if (ce) begin
                r_prod[1] <= w_prod_s1;
                for (int k = 2; k < c_NPIPE; k++) begin
                    r_prod[k] <= r_prod[k-1];
                end
            end
        end

        assign w_prod = r_prod[c_NPIPE-1];
    end else begin : g_prod_comb
        assign w_prod = w_prod_s1;
    end

    // ---------------- accumulate stage ----------------
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_ovf;
    logic                        r_emit;
    logic signed [ACC_WIDTH-1:0] w_acc_base;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_ovf_base;
    logic                        w_ovf_next;
    wide_t                       w_sum;
    sat_t                        w_acc_sat;
    logic                        w_unused_acc_hi;

    always_comb begin
        // acc_first restarts the sum and clears the sticky overflow.
        w_acc_base = r_first[c_NPIPE-1] ? '0 : r_acc;
        w_ovf_base = r_first[c_NPIPE-1] ? 1'b0 : r_ovf;
        // Wide add cannot wrap; the clamp then pins it to the accumulator range.
        w_sum      = wide_t'(w_acc_base) + wide_t'(w_prod);
        w_acc_sat  = sat_signed(w_sum, ACC_WIDTH);
        w_acc_next = w_acc_sat.value[ACC_WIDTH-1:0];
        w_ovf_next = w_ovf_base | w_acc_sat.clamped;
    end

    assign w_unused_acc_hi = ^w_acc_sat.value[c_MAX_WIDTH-1:ACC_WIDTH];

    // Invalid beats leave acc/ovf untouched so a sum may contain gaps.
    // r_emit marks that r_acc/r_ovf now hold the closing beat's acc_next/ovf_next.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_emit <= 1'b0;
        end else if (ce) begin
            if (r_vld[c_NPIPE-1]) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
            end
            r_emit <= r_vld[c_NPIPE-1] & r_last[c_NPIPE-1];
        end
    end

    // ---------------- output stage ----------------
    logic signed [DOUT_WIDTH-1:0] w_dout;
    logic                         w_clamped;
    logic                         r_out_valid;
    logic signed [DOUT_WIDTH-1:0] r_dout;
    logic                         r_sat;

    mpc_mac_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT)
    ) u_sat (
        .i_acc     (r_acc),
        .o_dout    (w_dout),
        .o_clamped (w_clamped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_sat       <= 1'b0;
        end else if (ce) begin
            r_out_valid <= r_emit;
            if (r_emit) begin
                r_dout <= w_dout;
                r_sat  <= r_ovf | w_clamped;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.sat_flag  = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_mpc_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpc_mac_pipe
// Description : Self-checking bench for mpc_mac_pipe. Two instances share the
//               same beat stream (SHIFT=0 and SHIFT=4); an arithmetic model
//               queues expected results, a negedge monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mpc_mac_pipe;
    localparam int unsigned c_DIN0_W = 21;
    localparam int unsigned c_DIN1_W = 7;
    localparam int unsigned c_DOUT_W = 28;
    localparam int unsigned c_ACC_W  = 40;
    localparam int unsigned c_NSTAGE = 4;
    localparam longint      c_AMAX   = (longint'(1) <<< (c_ACC_W - 1)) - 1;
    localparam longint      c_AMIN   = -(longint'(1) <<< (c_ACC_W - 1));
    localparam longint      c_DMAX   = (longint'(1) <<< (c_DOUT_W - 1)) - 1;
    localparam longint      c_DMIN   = -(longint'(1) <<< (c_DOUT_W - 1));

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ce    = 1'b1;
    always #5 clk = ~clk;

    logic                       s_valid = 1'b0;
    logic                       s_first = 1'b0;
    logic                       s_last  = 1'b0;
    logic signed [c_DIN0_W-1:0] s_din0  = '0;
    logic signed [c_DIN1_W-1:0] s_din1  = '0;

    mpc_mac_pipe_if #(.DIN0_WIDTH(c_DIN0_W), .DIN1_WIDTH(c_DIN1_W), .DOUT_WIDTH(c_DOUT_W)) if0 ();
    mpc_mac_pipe_if #(.DIN0_WIDTH(c_DIN0_W), .DIN1_WIDTH(c_DIN1_W), .DOUT_WIDTH(c_DOUT_W)) if4 ();

    assign if0.in_valid  = s_valid;
    assign if0.din0      = s_din0;
    assign if0.din1      = s_din1;
    assign if0.acc_first = s_first;
    assign if0.acc_last  = s_last;
    assign if4.in_valid  = s_valid;
    assign if4.din0      = s_din0;
    assign if4.din1      = s_din1;
    assign if4.acc_first = s_first;
    assign if4.acc_last  = s_last;

    mpc_mac_pipe #(
        .DIN0_WIDTH(c_DIN0_W), .DIN1_WIDTH(c_DIN1_W), .DOUT_WIDTH(c_DOUT_W),
        .ACC_WIDTH(c_ACC_W), .NUM_STAGE(c_NSTAGE), .SHIFT(0)
    ) u_dut0 (.clk(clk), .reset(reset), .ce(ce), .bus(if0));

    mpc_mac_pipe #(
        .DIN0_WIDTH(c_DIN0_W), .DIN1_WIDTH(c_DIN1_W), .DOUT_WIDTH(c_DOUT_W),
        .ACC_WIDTH(c_ACC_W), .NUM_STAGE(c_NSTAGE), .SHIFT(4)
    ) u_dut4 (.clk(clk), .reset(reset), .ce(ce), .bus(if4));

    typedef struct {
        longint      dout;
        bit          sat;
        int unsigned due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q4[$];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int unsigned ncy     = 0;
    bit          rst_edge = 1'b1;
    bit          ce_edge  = 1'b1;
    bit          started  = 1'b0;
    longint      m_acc    = 0;
    bit          m_ovf    = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (ce-cycle %0d)", nm, ncy);
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if (((a % b) != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Expected result from the exact sum: scale by 2^sh rounding half up, then clamp.
    function automatic exp_t make_exp(input longint acc, input bit ovf, input int unsigned sh,
                                      input int unsigned due);
        exp_t   e;
        longint v;
        v = acc;
        if (sh > 0) v = floor_div(acc + (longint'(1) << (sh - 1)), longint'(1) << sh);
        e.sat = ovf;
        if (v > c_DMAX) begin v = c_DMAX; e.sat = 1'b1; end
        if (v < c_DMIN) begin v = c_DMIN; e.sat = 1'b1; end
        e.dout = v;
        e.due  = due;
        return e;
    endfunction

    function automatic int q_size(input int id);
        return (id == 0) ? q0.size() : q4.size();
    endfunction

    function automatic exp_t q_pop(input int id);
        if (id == 0) return q0.pop_front();
        return q4.pop_front();
    endfunction

    function automatic int unsigned q_due(input int id);
        return (id == 0) ? q0[0].due : q4[0].due;
    endfunction

    // Reference model: sums products of accepted beats.
    always @(posedge clk) begin
        longint p;
        rst_edge = reset;
        ce_edge  = ce;
        if (reset) begin
            m_acc = 0;
            m_ovf = 1'b0;
            q0.delete();
            q4.delete();
        end else if (ce) begin
            ncy++;
            if (s_valid) begin
                p = longint'(s_din0) * longint'(s_din1);
                if (s_first) begin
                    m_acc = 0;
                    m_ovf = 1'b0;
                end
                m_acc = m_acc + p;
                if (m_acc > c_AMAX) begin m_acc = c_AMAX; m_ovf = 1'b1; end
                if (m_acc < c_AMIN) begin m_acc = c_AMIN; m_ovf = 1'b1; end
                if (s_last) begin
                    q0.push_back(make_exp(m_acc, m_ovf, 0, ncy + c_NSTAGE - 1));
                    q4.push_back(make_exp(m_acc, m_ovf, 4, ncy + c_NSTAGE - 1));
                end
            end
        end
    end

    task automatic mon_one(input string nm, input int id, input logic ov,
                           input longint d, input logic s);
        exp_t e;
        if (ov) begin
            if (q_size(id) == 0) begin
                fail_now({nm, " out_valid with no expected result"});
            end else begin
                e = q_pop(id);
                check({nm, " dout"}, d, e.dout);
                check({nm, " sat_flag"}, longint'(s), longint'(e.sat));
                check({nm, " latency"}, longint'(ncy), longint'(e.due));
            end
        end else if ((q_size(id) > 0) && (q_due(id) <= ncy)) begin
            e = q_pop(id);
            fail_now({nm, " out_valid missing at due cycle"});
        end
    endtask

    logic   p_ov0, p_s0, p_ov4, p_s4;
    longint p_d0, p_d4;

    always @(negedge clk) begin
        if (started && !rst_edge) begin
            if (ce_edge) begin
                mon_one("dut0", 0, if0.out_valid, longint'(if0.dout), if0.sat_flag);
                mon_one("dut4", 1, if4.out_valid, longint'(if4.dout), if4.sat_flag);
            end else begin
                check("dut0 hold out_valid", longint'(if0.out_valid), longint'(p_ov0));
                check("dut0 hold dout", longint'(if0.dout), p_d0);
                check("dut0 hold sat_flag", longint'(if0.sat_flag), longint'(p_s0));
                check("dut4 hold dout", longint'(if4.dout), p_d4);
                check("dut4 hold out_valid", longint'(if4.out_valid), longint'(p_ov4));
                check("dut4 hold sat_flag", longint'(if4.sat_flag), longint'(p_s4));
            end
        end
        p_ov0 = if0.out_valid;
        p_d0  = longint'(if0.dout);
        p_s0  = if0.sat_flag;
        p_ov4 = if4.out_valid;
        p_d4  = longint'(if4.dout);
        p_s4  = if4.sat_flag;
    end

    task automatic beat(input longint a, input longint b, input bit f, input bit l);
        @(negedge clk);
        s_valid = 1'b1;
        s_din0  = c_DIN0_W'(a);
        s_din1  = c_DIN1_W'(b);
        s_first = f;
        s_last  = l;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_first = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dut0 out_valid", longint'(if0.out_valid), 0);
        check("reset dut0 dout", longint'(if0.dout), 0);
        check("reset dut0 sat_flag", longint'(if0.sat_flag), 0);
        check("reset dut4 out_valid", longint'(if4.out_valid), 0);
        check("reset dut4 dout", longint'(if4.dout), 0);
        check("reset dut4 sat_flag", longint'(if4.sat_flag), 0);
        reset   = 1'b0;
        started = 1'b1;

        // Plain single product, extreme negative operands.
        beat(-1048576, -64, 1, 1);
        idle(6);

        // Four-beat sum that overflows the output range.
        beat(1048575, 63, 1, 0);
        beat(1048575, 63, 0, 0);
        beat(1048575, 63, 0, 0);
        beat(1048575, 63, 0, 1);
        idle(6);

        // Back-to-back single beats.
        for (int i = 1; i <= 8; i++) beat(i, 3, 1, 1);
        idle(6);

        // Stall for three cycles with two beats in flight.
        beat(11, -5, 1, 1);
        beat(-9, 13, 1, 1);
        @(negedge clk);
        s_valid = 1'b0;
        ce      = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        idle(6);

        // Reset in the middle of an open sum.
        beat(100, 7, 1, 0);
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        beat(5, 3, 0, 1);
        idle(6);

        // Rounding cases seen by the SHIFT=4 instance.
        beat(24, 1, 1, 1);
        beat(-24, 1, 1, 1);
        beat(8, 1, 1, 1);
        beat(7, 1, 1, 1);
        idle(6);

        // Random beats, framing and clock-enable gaps.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            ce      = ($urandom_range(0, 4) != 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_first = ($urandom_range(0, 3) == 0);
            s_last  = ($urandom_range(0, 2) == 0);
            s_din0  = c_DIN0_W'($urandom);
            s_din1  = c_DIN1_W'($urandom);
        end
        @(negedge clk);
        ce = 1'b1;
        idle(1);

        for (int i = 0; (i < 60) && ((q0.size() + q4.size()) > 0); i++) @(negedge clk);
        while (q0.size() > 0) begin
            void'(q0.pop_front());
            fail_now("dut0 expected result never appeared");
        end
        while (q4.size() > 0) begin
            void'(q4.pop_front());
            fail_now("dut4 expected result never appeared");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
